// File: rtl/pulse_generator_pkg.sv
// Shared types for the pulse generator: FSM state encoding and output level constants.
package pulse_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pg_state_e;

  localparam logic LVL_HIGH = 1'b1;
  localparam logic LVL_LOW  = 1'b0;

endpackage

// File: rtl/saturating_counter.sv
// Pending-request counter: up/down by one, holds at all-ones and flags that condition.
module saturating_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] MAX = '1;

  assign saturated = (count == MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !saturated) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// Queued pulse generator: each trigger yields a high pulse of high_cycles followed by
// at least low_cycles of low time; requests arriving mid-pulse wait in a saturating queue.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int WIDTH_BITS = 16,
  parameter int QUEUE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [WIDTH_BITS-1:0] high_cycles,
  input  logic [WIDTH_BITS-1:0] low_cycles,
  output logic                  level,
  output logic                  busy,
  output logic [QUEUE_BITS-1:0] pending,
  output logic                  done,
  output logic                  overflow
);

  pg_state_e             state, state_nxt;
  logic [WIDTH_BITS-1:0] cnt, cnt_nxt;
  logic [WIDTH_BITS-1:0] hi_lat, hi_nxt;
  logic [WIDTH_BITS-1:0] lo_lat, lo_nxt;
  logic                  done_nxt;
  logic                  ready, start;
  logic                  q_inc, q_dec, q_full;

  // A zero request still yields one cycle, so pulses never merge.
  function automatic logic [WIDTH_BITS-1:0] at_least_one(input logic [WIDTH_BITS-1:0] v);
    return (v == '0) ? WIDTH_BITS'(1) : v;
  endfunction

  assign busy  = (state != IDLE);
  assign ready = (state == IDLE) || ((state == GAP) && (cnt == '0));
  assign start = ready && ((pending != '0) || trigger);

  // A start with an empty queue consumes the same-cycle trigger directly.
  assign q_inc = trigger && !start;
  assign q_dec = start && (pending != '0) && !trigger;

  saturating_counter #(.WIDTH(QUEUE_BITS)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .inc       (q_inc),
    .dec       (q_dec),
    .count     (pending),
    .saturated (q_full)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_lat;
    lo_nxt    = lo_lat;
    done_nxt  = 1'b0;
    case (state)
      HIGH: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = lo_lat - WIDTH_BITS'(1);
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - WIDTH_BITS'(1);
        end
      end
      GAP: begin
        if (cnt != '0) cnt_nxt = cnt - WIDTH_BITS'(1);
        else           state_nxt = IDLE;
      end
      default: ;
    endcase
    if (start) begin
      state_nxt = HIGH;
      hi_nxt    = at_least_one(high_cycles);
      lo_nxt    = at_least_one(low_cycles);
      cnt_nxt   = at_least_one(high_cycles) - WIDTH_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_lat   <= '0;
      lo_lat   <= '0;
      level    <= LVL_LOW;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hi_lat   <= hi_nxt;
      lo_lat   <= lo_nxt;
      level    <= (state_nxt == HIGH) ? LVL_HIGH : LVL_LOW;
      done     <= done_nxt;
      overflow <= q_inc && q_full;
    end
  end

endmodule
